scroll_sprite_compositor: RTL and testbench

//   Pipelined pixel compositor: scrolled, scaled background map plus NUM_SPRITES

---
 rtl/scroll_sprite_compositor.sv | 197 +++++++++++++++++++
 tb/tb_scroll_sprite_compositor.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/scroll_sprite_compositor.sv
// Pixel compositor: scrolled/scaled background map plus NUM_SPRITES prioritised sprites.
// Optional build macro SCROLL_CLAMP_EN clamps the frame-start scroll latch to the map extent.

module ssc_spr_chan #(
    parameter int SPR_SIZE = 75,
    parameter int DEG_W    = 4,
    parameter int SAW      = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       h_cnt,
    input  logic [9:0]       v_cnt,
    input  logic             en,
    input  logic [9:0]       x,
    input  logic [9:0]       y,
    input  logic [DEG_W-1:0] deg,
    output logic             hit,
    output logic [SAW-1:0]   addr_q
);
    logic [10:0]    px, py;
    logic [SAW-1:0] addr_d;

    // 11-bit signed offsets: a negative result (bit 10) means left of / above the sprite
    always_comb begin
        px     = {1'b0, h_cnt} - {1'b0, x};
        py     = {1'b0, v_cnt} - {1'b0, y};
        hit    = en & ~px[10] & ~py[10] & (px < 11'(SPR_SIZE)) & (py < 11'(SPR_SIZE));
        addr_d = '0;
        if (hit)
            addr_d = SAW'(deg) * SAW'(SPR_SIZE * SPR_SIZE) + SAW'(py) * SAW'(SPR_SIZE) + SAW'(px);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) addr_q <= '0;
        else      addr_q <= addr_d;
    end
endmodule

module scroll_sprite_compositor #(
    parameter int          MAP_W       = 320,
    parameter int          MAP_H       = 240,
    parameter int          SCALE_SHIFT = 1,
    parameter int          H_ACTIVE    = 640,
    parameter int          V_ACTIVE    = 480,
    parameter int          NUM_SPRITES = 2,
    parameter int          SPR_SIZE    = 75,
    parameter int          SPR_DIRS    = 16,
    parameter int          BRAM_LAT    = 1,
    parameter logic [11:0] OOB_COLOR   = 12'h6B4,
    parameter logic [11:0] KEY_COLOR   = 12'h000,
    localparam int         MAW         = $clog2(MAP_W * MAP_H),
    localparam int         SAW         = $clog2(SPR_DIRS * SPR_SIZE * SPR_SIZE),
    localparam int         DEG_W       = $clog2(SPR_DIRS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                valid,
    input  logic [9:0]                          h_cnt,
    input  logic [9:0]                          v_cnt,
    input  logic                                hsync_in,
    input  logic                                vsync_in,
    input  logic                                frame_start,
    input  logic [9:0]                          scroll_x,
    input  logic [9:0]                          scroll_y,
    input  logic [NUM_SPRITES-1:0]              spr_en,
    input  logic [NUM_SPRITES-1:0][9:0]         spr_x,
    input  logic [NUM_SPRITES-1:0][9:0]         spr_y,
    input  logic [NUM_SPRITES-1:0][DEG_W-1:0]   spr_deg,
    output logic [MAW-1:0]                      map_addr,
    input  logic [11:0]                         map_data,
    output logic [NUM_SPRITES-1:0][SAW-1:0]     spr_addr,
    input  logic [NUM_SPRITES-1:0][11:0]        spr_data,
    output logic [3:0]                          vgaRed,
    output logic [3:0]                          vgaGreen,
    output logic [3:0]                          vgaBlue,
    output logic                                hsync,
    output logic                                vsync
);
    localparam int SX_RAW = MAP_W - (H_ACTIVE >> SCALE_SHIFT);
    localparam int SY_RAW = MAP_H - (V_ACTIVE >> SCALE_SHIFT);
    localparam int SX_LIM = (SX_RAW < 0) ? 0 : SX_RAW;
    localparam int SY_LIM = (SY_RAW < 0) ? 0 : SY_RAW;

    typedef struct packed {
        logic                   vld;
        logic                   oob;
        logic [NUM_SPRITES-1:0] hit;
        logic                   hs;
        logic                   vs;
    } sb_t;

    logic [9:0]             sx_q, sy_q, sx_d, sy_d;
    logic [10:0]            mx, my;
    logic                   oob;
    logic [21:0]            map_lin;
    logic [MAW-1:0]         map_addr_q, map_addr_d;
    logic [NUM_SPRITES-1:0] hit;
    sb_t                    sb_pipe_q [BRAM_LAT:0];
    sb_t                    sb_c;
    logic [11:0]            color_q, color_d;
    logic                   hs_q, vs_q, found;

`ifdef SCROLL_CLAMP_EN
    always_comb begin
        sx_d = (int'(scroll_x) > SX_LIM) ? 10'(SX_LIM) : scroll_x;
        sy_d = (int'(scroll_y) > SY_LIM) ? 10'(SY_LIM) : scroll_y;
    end
`else
    always_comb begin
        sx_d = scroll_x;
        sy_d = scroll_y;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sx_q <= '0;
            sy_q <= '0;
        end else if (frame_start) begin
            sx_q <= sx_d;
            sy_q <= sy_d;
        end
    end

    // Stage A: background address, 11-bit sums so an over-scrolled pixel reads as out-of-map
    always_comb begin
        mx         = 11'(h_cnt >> SCALE_SHIFT) + {1'b0, sx_q};
        my         = 11'(v_cnt >> SCALE_SHIFT) + {1'b0, sy_q};
        oob        = (mx >= 11'(MAP_W)) | (my >= 11'(MAP_H));
        map_lin    = 22'(my) * 22'(MAP_W) + 22'(mx);
        map_addr_d = oob ? '0 : MAW'(map_lin);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_spr
            ssc_spr_chan #(.SPR_SIZE(SPR_SIZE), .DEG_W(DEG_W), .SAW(SAW)) u_chan (
                .clk    (clk),
                .rst    (rst),
                .h_cnt  (h_cnt),
                .v_cnt  (v_cnt),
                .en     (spr_en[gi]),
                .x      (spr_x[gi]),
                .y      (spr_y[gi]),
                .deg    (spr_deg[gi]),
                .hit    (hit[gi]),
                .addr_q (spr_addr[gi])
            );
        end
    endgenerate

    // Side-band rides alongside the BRAM reads so stage C sees it together with the data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            map_addr_q <= '0;
            for (int k = 0; k <= BRAM_LAT; k++) sb_pipe_q[k] <= '0;
        end else begin
            map_addr_q   <= map_addr_d;
            sb_pipe_q[0] <= '{vld: valid, oob: oob, hit: hit, hs: hsync_in, vs: vsync_in};
            for (int k = 1; k <= BRAM_LAT; k++) sb_pipe_q[k] <= sb_pipe_q[k-1];
        end
    end

    assign sb_c     = sb_pipe_q[BRAM_LAT];
    assign map_addr = map_addr_q;

    // Stage C: blanking, then sprites by index, then out-of-map, then background
    always_comb begin
        color_d = '0;
        found   = 1'b0;
        if (sb_c.vld) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (!found && sb_c.hit[i] && spr_data[i] != KEY_COLOR) begin
                    color_d = spr_data[i];
                    found   = 1'b1;
                end
            end
            if (!found) color_d = sb_c.oob ? OOB_COLOR : map_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            color_q <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
        end else begin
            color_q <= color_d;
            hs_q    <= sb_c.hs;
            vs_q    <= sb_c.vs;
        end
    end

    assign {vgaRed, vgaGreen, vgaBlue} = color_q;
    assign hsync = hs_q;
    assign vsync = vs_q;
endmodule

// File: tb/tb_scroll_sprite_compositor.sv
// Directed bench for scroll_sprite_compositor with behavioural map/sprite BRAMs (latency 1).
module tb_scroll_sprite_compositor;
    localparam int NS  = 2;
    localparam int MAW = 17;
    localparam int SAW = 17;

    logic               clk = 1'b0;
    logic               rst;
    logic               valid, hsync_in, vsync_in, frame_start;
    logic [9:0]         h_cnt, v_cnt, scroll_x, scroll_y;
    logic [NS-1:0]      spr_en;
    logic [NS-1:0][9:0] spr_x, spr_y;
    logic [NS-1:0][3:0] spr_deg;
    logic [MAW-1:0]     map_addr;
    logic [11:0]        map_data;
    logic [NS-1:0][SAW-1:0] spr_addr;
    logic [NS-1:0][11:0]    spr_data;
    logic [3:0]         vgaRed, vgaGreen, vgaBlue;
    logic               hsync, vsync;
    logic [1:0]         key;
    logic [11:0]        rgb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scroll_sprite_compositor dut (
        .clk(clk), .rst(rst), .valid(valid), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .frame_start(frame_start),
        .scroll_x(scroll_x), .scroll_y(scroll_y), .spr_en(spr_en), .spr_x(spr_x),
        .spr_y(spr_y), .spr_deg(spr_deg), .map_addr(map_addr), .map_data(map_data),
        .spr_addr(spr_addr), .spr_data(spr_data), .vgaRed(vgaRed), .vgaGreen(vgaGreen),
        .vgaBlue(vgaBlue), .hsync(hsync), .vsync(vsync)
    );

    assign rgb = {vgaRed, vgaGreen, vgaBlue};

    function automatic logic [11:0] map_f(input logic [MAW-1:0] a);
        return a[11:0] ^ 12'h5A5;
    endfunction

    function automatic logic [11:0] spr_f(input int i, input logic [SAW-1:0] a);
        return {(i == 0) ? 4'hA : 4'hC, a[7:0]};
    endfunction

    // Behavioural BRAMs; key[i] forces sprite i to the transparent colour
    always @(posedge clk) begin
        map_data <= map_f(map_addr);
        for (int i = 0; i < NS; i++)
            spr_data[i] <= key[i] ? 12'h000 : spr_f(i, spr_addr[i]);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [9:0]     h, v;
        logic           vld;
        logic [1:0]     en, key;
        logic [MAW-1:0] e_map;
        logic [SAW-1:0] e_spr0;
        logic [11:0]    e_rgb;
    } vec_t;

    vec_t tv [12];
    logic [15:0] hp, vp;

    initial begin
        tv[0]  = '{10'd0,   10'd0,   1'b1, 2'b00, 2'b00, 17'd0,     17'd0,     map_f(17'd0)};
        tv[1]  = '{10'd100, 10'd50,  1'b1, 2'b00, 2'b00, 17'd8050,  17'd0,     map_f(17'd8050)};
        tv[2]  = '{10'd284, 10'd205, 1'b1, 2'b11, 2'b00, 17'd32782, 17'd17026, spr_f(0, 17'd17026)};
        tv[3]  = '{10'd284, 10'd205, 1'b1, 2'b11, 2'b01, 17'd32782, 17'd17026, spr_f(1, 17'd17026)};
        tv[4]  = '{10'd284, 10'd205, 1'b1, 2'b11, 2'b11, 17'd32782, 17'd17026, map_f(17'd32782)};
        tv[5]  = '{10'd284, 10'd205, 1'b1, 2'b00, 2'b00, 17'd32782, 17'd0,     map_f(17'd32782)};
        tv[6]  = '{10'd284, 10'd205, 1'b0, 2'b11, 2'b00, 17'd32782, 17'd17026, 12'h000};
        tv[7]  = '{10'd357, 10'd277, 1'b1, 2'b11, 2'b00, 17'd44338, 17'd22499, spr_f(0, 17'd22499)};
        tv[8]  = '{10'd358, 10'd277, 1'b1, 2'b11, 2'b00, 17'd44339, 17'd0,     map_f(17'd44339)};
        tv[9]  = '{10'd282, 10'd203, 1'b1, 2'b11, 2'b00, 17'd32461, 17'd0,     map_f(17'd32461)};
        tv[10] = '{10'd639, 10'd479, 1'b1, 2'b00, 2'b00, 17'd76799, 17'd0,     map_f(17'd76799)};
        tv[11] = '{10'd284, 10'd205, 1'b1, 2'b10, 2'b00, 17'd32782, 17'd0,     spr_f(1, 17'd17026)};

        rst = 1'b0; valid = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; frame_start = 1'b0;
        h_cnt = '0; v_cnt = '0; scroll_x = '0; scroll_y = '0; key = '0;
        spr_en = '0; spr_x = {10'd283, 10'd283}; spr_y = {10'd203, 10'd203};
        spr_deg = {4'd3, 4'd3};

        repeat (2) @(negedge clk);
        chk("reset_rgb", 32'(rgb), 32'h0);
        chk("reset_syncs", {30'b0, hsync, vsync}, 32'h3);
        chk("reset_map_addr", 32'(map_addr), 32'h0);
        rst = 1'b1;

        for (int n = 0; n < 12; n++) begin
            h_cnt = tv[n].h; v_cnt = tv[n].v; valid = tv[n].vld;
            spr_en = tv[n].en; key = tv[n].key;
            @(negedge clk);
            chk($sformatf("vec%0d_map_addr", n), 32'(map_addr), 32'(tv[n].e_map));
            chk($sformatf("vec%0d_spr_addr0", n), 32'(spr_addr[0]), 32'(tv[n].e_spr0));
            repeat (2) @(negedge clk);
            chk($sformatf("vec%0d_rgb", n), 32'(rgb), 32'(tv[n].e_rgb));
        end

        // Scroll request is ignored until frame_start
        spr_en = '0; key = '0; valid = 1'b1; h_cnt = 10'd0; v_cnt = 10'd0; scroll_x = 10'd40;
        @(negedge clk);
        chk("scroll_held", 32'(map_addr), 32'h0);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        chk("scroll40_map_addr", 32'(map_addr), 32'd40);
        repeat (2) @(negedge clk);
        chk("scroll40_rgb", 32'(rgb), 32'(map_f(17'd40)));

        // Over-scroll: out-of-map unless clamped
        scroll_x = 10'd300; frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0; h_cnt = 10'd80;
        @(negedge clk);
`ifdef SCROLL_CLAMP_EN
        chk("scroll300_map_addr", 32'(map_addr), 32'd40);
        repeat (2) @(negedge clk);
        chk("scroll300_rgb", 32'(rgb), 32'(map_f(17'd40)));
`else
        chk("scroll300_map_addr", 32'(map_addr), 32'd0);
        repeat (2) @(negedge clk);
        chk("scroll300_rgb", 32'(rgb), 32'h6B4);
`endif

        // Mid-line reset: immediate effect, frame_start inside reset is ignored
        h_cnt = 10'd0; hsync_in = 1'b0; vsync_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_syncs", {30'b0, hsync, vsync}, 32'h0);
        #2 rst = 1'b0; frame_start = 1'b1; scroll_x = 10'd100;
        #1;
        chk("midreset_rgb", 32'(rgb), 32'h0);
        chk("midreset_syncs", {30'b0, hsync, vsync}, 32'h3);
        @(negedge clk);
        rst = 1'b1; frame_start = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        @(negedge clk);
        chk("post_reset_map_addr", 32'(map_addr), 32'h0);

        // Sync delay line, with valid low and addresses still moving
        hp = 16'b1011_0010_0111_0100;
        vp = 16'b0110_1100_1000_1101;
        valid = 1'b0;
        for (int t = 0; t < 19; t++) begin
            @(negedge clk);
            if (t >= 3) begin
                chk($sformatf("hsync_t%0d", t), {31'b0, hsync}, {31'b0, hp[t-3]});
                chk($sformatf("vsync_t%0d", t), {31'b0, vsync}, {31'b0, vp[t-3]});
                chk($sformatf("blank_rgb_t%0d", t), 32'(rgb), 32'h0);
            end
            if (t < 16) begin
                hsync_in = hp[t]; vsync_in = vp[t]; h_cnt = 10'(2 * t);
            end
        end
        chk("blank_map_addr", 32'(map_addr), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
